updown_step_counter: RTL
========================

Name: updown_step_counter

Overview:
- Responder side of the go/done counter handshake used by the LED sequencing tops. A single counter waits for a one-cycle go, counts up or down one step per tick, then returns a one-cycle done.
- Contains its own tick prescaler, so the whole design runs on the 12 MHz system clock and needs no derived clock.
- Chains directly to a sequencer or to a second instance: one instance's done drives the other's go.

Parameters:
- WIDTH, 4, width of the count output.
- MAX_COUNT, 15, top count value; must fit in WIDTH bits.
- TICK_DIV, 3000000, system clocks per count step; must be >= 1.
- TICK_WIDTH, 24, prescaler counter width; must satisfy TICK_DIV-1 < 2^TICK_WIDTH.

Ports:
- clk  input  1  system clock, 12 MHz.
- rst  input  1  reset, asynchronous, active-high.
- go  input  1  start request, one-cycle pulse; accepted only in IDLE.
- up  input  1  direction, sampled only on the accepted go cycle; 1 = up, 0 = down.
- stop  input  1  abort; returns the block to IDLE without a done pulse.
- out  output  WIDTH  current count value, registered.
- busy  output  1  high in COUNTING and DONE.
- done  output  1  one-clk pulse on completion, registered.

Behaviour:
- Reset, asynchronous, active-high, so it takes effect immediately, mid-count included:
  - state = IDLE, out = 0, busy = 0, done = 0, prescaler = 0, latched direction = up.
- States: IDLE, COUNTING, DONE, all registered.
- IDLE:
  - out holds its last value.
  - On go=1 and stop=0: latch dir <= up; out <= (up ? 0 : MAX_COUNT); prescaler <= 0; go to COUNTING.
- COUNTING:
  - Prescaler counts 0 to TICK_DIV-1 and wraps; the tick is the cycle where prescaler == TICK_DIV-1.
  - On tick, if out == terminal (MAX_COUNT when up, 0 when down): go to DONE and leave out unchanged.
  - Otherwise on tick: out <= out+1 (up) or out-1 (down).
  - out never wraps past 0 or MAX_COUNT.
- DONE: done = 1 for exactly one clk, then unconditionally return to IDLE. out keeps the terminal value.
- Timing:
  - Each value is held for TICK_DIV clks.
  - done rises (MAX_COUNT+1)*TICK_DIV clks after the clock edge that accepts go.
  - Registered outputs change on the edge after the causing input; there are no combinational paths from input to output.
- go while busy (COUNTING or DONE) is ignored, and up is ignored with it. Because done lasts one cycle, a go coincident with done on the same instance is lost; that is by design.
- stop:
  - In COUNTING or DONE: next state IDLE, done stays 0, out frozen at its current value, prescaler cleared.
  - In IDLE: no effect.
  - go and stop together in IDLE: stop wins and the block stays in IDLE.
- TICK_DIV = 1: tick fires every cycle, so out steps every clk.

Decomposition:
- Shared package: state encoding constants ST_IDLE, ST_COUNTING, ST_DONE (2-bit), reused by the other go/done FSMs.
- One sub-module, step_tick_gen (params TICK_DIV, TICK_WIDTH; ports clk, rst, clr, en, tick). It is the free-running prescaler with synchronous clear on go or stop, and enable while COUNTING.
- Everything else (state register, direction latch, count register) stays in updown_step_counter.

Test Plan:
- Reset mid-count (WIDTH=4, MAX_COUNT=3, TICK_DIV=2) -> after rst pulse: out=0, busy=0, done=0 immediately, before any clk edge.
- Count up (same params): go=1, up=1 for 1 clk -> out sequence 0,0,1,1,2,2,3,3 (one value per clk); done=1 for exactly 1 clk, 8 clks after the accepting edge; busy falls the clk after done.
- Count down (same params): go=1, up=0 -> out 3,3,2,2,1,1,0,0; done pulse after 8 clks; out holds 0 in IDLE.
- go and up toggled repeatedly while busy -> count and direction unaffected, exactly one done pulse; then go in IDLE restarts from 0.
- stop at out=2 during up count -> next clk state IDLE, busy=0, out=2, no done.
- stop with go in IDLE -> out, busy and done unchanged.
- Two instances chained, A.done -> B.go (B up=0), B.done -> A.go (A up=1), TICK_DIV=1, MAX_COUNT=3 -> A ramps 0..3, B ramps 3..0, alternation repeats, never both busy except the single handoff cycle.

Source files
------------

// File: rtl/updown_step_counter_pkg.sv
// Shared state encoding for the go/done handshake FSMs used by the LED
// sequencing tops.
package updown_step_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNTING = 2'd1,
        ST_DONE     = 2'd2
    } state_e;

endpackage

// File: rtl/updown_step_counter_step_tick_gen.sv
// Free-running prescaler: emits a one-cycle tick every TICK_DIV enabled clocks,
// restarting from zero whenever clr is asserted.
module step_tick_gen #(
    parameter int TICK_DIV   = 3000000,
    parameter int TICK_WIDTH = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [TICK_WIDTH-1:0] LAST = TICK_WIDTH'(TICK_DIV - 1);

    logic [TICK_WIDTH-1:0] cnt_q;
    logic [TICK_WIDTH-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + TICK_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/updown_step_counter.sv
// Go/done responder: on an accepted go, steps out up or down once per prescaler
// tick until the terminal value, then pulses done for one clock.
module updown_step_counter
    import updown_step_counter_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int MAX_COUNT  = 15,
    parameter int TICK_DIV   = 3000000,
    parameter int TICK_WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             up,
    input  logic             stop,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

    state_e           state_q, state_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic accept;
    logic tick;
    logic at_term;

    assign accept  = (state_q == ST_IDLE) && go && !stop;
    assign at_term = dir_q ? (out_q == MAX_VAL) : (out_q == '0);

    // Clearing on stop as well means an aborted count restarts with a full period.
    step_tick_gen #(
        .TICK_DIV   (TICK_DIV),
        .TICK_WIDTH (TICK_WIDTH)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept || stop),
        .en   (state_q == ST_COUNTING),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    dir_d   = up;
                    out_d   = up ? '0 : MAX_VAL;
                    state_d = ST_COUNTING;
                end
            end
            ST_COUNTING: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (at_term) begin
                        state_d = ST_DONE;
                    end else begin
                        out_d = dir_q ? out_q + WIDTH'(1) : out_q - WIDTH'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b1;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
